// File: rtl/pipe_adder_param.sv
// Segmented-carry pipelined adder/subtractor: WIDTH bits split into STAGES segments,
// one segment per stage, with valid/ready flow control and a single global stall.
module pipe_adder_param #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned SEG  = WIDTH / STAGES;
   localparam int unsigned LAST = STAGES - 1;

   // Per-stage registers. a_q/b_q carry the skewed operands forward, r_q collects the
   // finished (deskewed) low segments, c_q is the inter-segment carry.
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] r_q [STAGES];
   logic             c_q [STAGES];
   logic             v_q [STAGES];
   logic             ovf_q;

   logic [WIDTH-1:0] a_src [STAGES];
   logic [WIDTH-1:0] b_src [STAGES];
   logic [WIDTH-1:0] r_src [STAGES];
   logic             c_src [STAGES];
   logic             v_src [STAGES];
   logic [WIDTH-1:0] r_nxt [STAGES];
   logic             c_nxt [STAGES];
   logic [SEG:0]     seg_sum;
   logic             ovf_nxt;
   logic             stall;

   assign stall     = v_q[LAST] && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = v_q[LAST];
   assign sum       = r_q[LAST];
   assign cout      = c_q[LAST];
   assign ovf       = ovf_q;

   // Stage 0 is fed by the prepared operands; later stages by their predecessor.
   always_comb begin
      a_src[0] = a;
      b_src[0] = sub ? ~b : b;
      r_src[0] = '0;
      c_src[0] = sub | cin;
      v_src[0] = in_valid;
      for (int unsigned k = 1; k < STAGES; k++) begin
         a_src[k] = a_q[k-1];
         b_src[k] = b_q[k-1];
         r_src[k] = r_q[k-1];
         c_src[k] = c_q[k-1];
         v_src[k] = v_q[k-1];
      end
   end

   always_comb begin
      seg_sum = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         seg_sum  = {1'b0, a_src[k][k*SEG +: SEG]}
                  + {1'b0, b_src[k][k*SEG +: SEG]}
                  + {{SEG{1'b0}}, c_src[k]};
         r_nxt[k] = r_src[k];
         r_nxt[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
         c_nxt[k] = seg_sum[SEG];
      end
   end

   assign ovf_nxt = (a_src[LAST][WIDTH-1] == b_src[LAST][WIDTH-1])
                 && (r_nxt[LAST][WIDTH-1] != a_src[LAST][WIDTH-1]);

   // Data registers load only behind a valid token so outputs keep their last result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            r_q[k] <= '0;
            c_q[k] <= 1'b0;
            v_q[k] <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (!stall) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            v_q[k] <= v_src[k];
            if (v_src[k]) begin
               a_q[k] <= a_src[k];
               b_q[k] <= b_src[k];
               r_q[k] <= r_nxt[k];
               c_q[k] <= c_nxt[k];
            end
         end
         if (v_src[LAST]) ovf_q <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_pipe_adder_param.sv
// Directed bench for pipe_adder_param: 16/4 main instance plus 8/1 and 8/8 variants.
module tb_pipe_adder_param;

   logic clk;
   logic rst_n;

   logic [15:0] a0, b0, s0;
   logic        ci0, su0, iv0, or0, ov0, ir0, co0, of0;
   logic [7:0]  a1, b1, s1;
   logic        ci1, su1, iv1, or1, ov1, ir1, co1, of1;
   logic [7:0]  a2, b2, s2;
   logic        ci2, su2, iv2, or2, ov2, ir2, co2, of2;

   int total = 0;
   int bad   = 0;

   pipe_adder_param #(.WIDTH(16), .STAGES(4)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
      .cin(ci0), .sub(su0), .out_valid(ov0), .out_ready(or0), .sum(s0), .cout(co0), .ovf(of0));

   pipe_adder_param #(.WIDTH(8), .STAGES(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
      .cin(ci1), .sub(su1), .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .ovf(of1));

   pipe_adder_param #(.WIDTH(8), .STAGES(8)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
      .cin(ci2), .sub(su2), .out_valid(ov2), .out_ready(or2), .sum(s2), .cout(co2), .ovf(of2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int d, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic su, input logic vi);
      case (d)
         0: begin a0 = a; b0 = b; ci0 = ci; su0 = su; iv0 = vi; end
         1: begin a1 = a[7:0]; b1 = b[7:0]; ci1 = ci; su1 = su; iv1 = vi; end
         default: begin a2 = a[7:0]; b2 = b[7:0]; ci2 = ci; su2 = su; iv2 = vi; end
      endcase
   endtask

   task automatic get_out(input int d, output logic v, output logic [15:0] s,
                          output logic co, output logic of, output logic r);
      case (d)
         0: begin v = ov0; s = s0; co = co0; of = of0; r = ir0; end
         1: begin v = ov1; s = {8'h00, s1}; co = co1; of = of1; r = ir1; end
         default: begin v = ov2; s = {8'h00, s2}; co = co2; of = of2; r = ir2; end
      endcase
   endtask

   // One isolated operation: checks exact latency, result fields, then drain.
   task automatic op(input int d, input int lat, input logic [15:0] a, input logic [15:0] b,
                     input logic ci, input logic su, input logic [15:0] es,
                     input logic ec, input logic eo, input string tag);
      logic v, co, of, r;
      logic [15:0] s;
      set_in(d, a, b, ci, su, 1'b1);
      tick();
      set_in(d, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < lat; i++) begin
         get_out(d, v, s, co, of, r);
         chk({tag, "_early"}, {15'b0, v}, 16'd0);
         tick();
      end
      get_out(d, v, s, co, of, r);
      chk({tag, "_valid"}, {15'b0, v}, 16'd1);
      chk({tag, "_sum"}, s, es);
      chk({tag, "_cout"}, {15'b0, co}, {15'b0, ec});
      chk({tag, "_ovf"}, {15'b0, of}, {15'b0, eo});
      tick();
      get_out(d, v, s, co, of, r);
      chk({tag, "_drain"}, {15'b0, v}, 16'd0);
   endtask

   initial begin
      logic v, co, of, r;
      logic [15:0] s, held;
      int sent, got;
      bit stalled_prev;

      rst_n = 1'b0;
      set_in(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      set_in(1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      set_in(2, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      or0 = 1'b1; or1 = 1'b1; or2 = 1'b1;

      // Reset then idle
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {15'b0, ov0}, 16'd0);
      chk("rst_sum", s0, 16'h0000);
      chk("rst_ready", {15'b0, ir0}, 16'd1);
      chk("rst_cout", {15'b0, co0}, 16'd0);
      chk("rst_ovf", {15'b0, of0}, 16'd0);
      chk("rst_valid_s1", {15'b0, ov1}, 16'd0);
      chk("rst_valid_s8", {15'b0, ov2}, 16'd0);
      rst_n = 1'b1;
      tick();
      tick();
      chk("idle_valid", {15'b0, ov0}, 16'd0);

      // Carry propagation and subtract
      op(0, 4, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "carry_seg");
      op(0, 4, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "carry_wrap");
      op(0, 4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
      op(0, 4, 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, "add_cin");
      op(0, 4, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
      op(0, 4, 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
      op(0, 4, 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_cin_ign");

      // Back-to-back stream: op k accepted at edge k+1, delivered after edge k+4
      for (int c = 0; c < 12; c++) begin
         if (c < 8) set_in(0, 16'(c + 5), 16'(c + 4), 1'b0, 1'b0, 1'b1);
         else       set_in(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
         tick();
         get_out(0, v, s, co, of, r);
         if (c >= 3 && c <= 10) begin
            chk("b2b_valid", {15'b0, v}, 16'd1);
            chk("b2b_sum", s, 16'(2 * (c - 3) + 9));
         end else begin
            chk("b2b_idle", {15'b0, v}, 16'd0);
         end
      end

      // Backpressure: consumer stalls for 3 cycles mid-stream
      sent = 0;
      got = 0;
      stalled_prev = 1'b0;
      held = '0;
      for (int c = 0; c < 24; c++) begin
         or0 = !(c >= 6 && c < 9);
         if (sent < 6) set_in(0, 16'((sent + 1) * 256 + 255), 16'h0001, 1'b0, 1'b0, 1'b1);
         else          set_in(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
         #1;
         get_out(0, v, s, co, of, r);
         if (v && or0) begin
            chk("bp_sum", s, 16'((got + 2) * 256));
            got++;
         end
         if (v && !or0) begin
            chk("bp_ready", {15'b0, r}, 16'd0);
            if (stalled_prev) chk("bp_hold", s, held);
            held = s;
         end
         stalled_prev = v && !or0;
         if (iv0 && r) sent++;
         tick();
      end
      chk("bp_delivered", 16'(got), 16'd6);
      chk("bp_sent", 16'(sent), 16'd6);
      or0 = 1'b1;

      // Reset while three operations are in flight
      for (int c = 0; c < 3; c++) begin
         set_in(0, 16'(c + 1), 16'(c + 2), 1'b0, 1'b0, 1'b1);
         tick();
      end
      set_in(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", {15'b0, ov0}, 16'd0);
      chk("midrst_ready", {15'b0, ir0}, 16'd1);
      chk("midrst_sum", s0, 16'h0000);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         chk("midrst_nostale", {15'b0, ov0}, 16'd0);
      end

      // Single-stage and one-bit-per-stage variants
      op(1, 1, 16'h0005, 16'h0004, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0, "s1_add");
      op(1, 1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "s1_wrap");
      op(1, 1, 16'h0080, 16'h0001, 1'b0, 1'b1, 16'h007F, 1'b1, 1'b1, "s1_sub_ovf");
      op(2, 8, 16'h0005, 16'h0004, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0, "s8_add");
      op(2, 8, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "s8_wrap");
      op(2, 8, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, "s8_ovf");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_adder_param.md
Name: pipe_adder_param

Overview:
- Parametrised, segmented-carry pipelined adder/subtractor. Successor to the fixed 8-bit pipelined adder (top_pipeline).
- Splits a WIDTH-bit add into STAGES equal segments, one segment per pipeline stage. Carry ripples stage to stage through registers.
- Adds valid/ready flow control, a subtract mode, carry-in, carry-out and signed overflow.
- Sits between operand producers and result consumers in the datapath.

Parameters:
- WIDTH, 16, operand/sum width in bits. Must be a multiple of STAGES and ≥ STAGES.
- STAGES, 4, number of pipeline stages (segments). Range 1..WIDTH. Segment width SEG = WIDTH/STAGES.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present this cycle.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A, unsigned/two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  1 = compute a-b, 0 = compute a+b+cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB (sub: 1 = no borrow).
- ovf  out  1  signed overflow.

Behaviour:
- Reset: rst_n low asynchronously clears every valid bit and all data/carry registers. While reset is asserted: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1. Reset mid-operation discards all in-flight operations; there is no partial output.
- Accept: a transfer occurs on a rising edge with in_valid && in_ready.
- Operand preparation at accept:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
- Stage k (0..STAGES-1) adds segment k of a and b_eff, plus the carry registered from stage k-1 (c0 for stage 0). It produces a SEG-bit result and a carry.
- Skew registers: upper operand segments are delayed so they reach stage k k cycles after accept.
- Deskew registers: lower result segments are delayed so all segments emerge together.
- Latency: exactly STAGES cycles from accepting edge to out_valid=1, when unstalled. STAGES=1 gives a single registered add.
- Throughput: one operation per cycle when unstalled.
- Ordering: results emerge in accept order. No reordering, no drop, no duplication.
- cout: carry out of the top segment.
- ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), computed with b_eff in the final stage.
- Flow control: global stall, stall = out_valid && !out_ready.
  - On stall, every pipeline register holds its value and in_ready=0.
  - in_ready = !stall (combinational from out_valid/out_ready).
  - Bubbles are not collapsed; an empty output slot never stalls the pipeline.
- Output hold: sum/cout/ovf are stable while out_valid=1 and out_ready=0.
- Output clearing: when no valid result is present, sum/cout/ovf hold their last value. The bench must not check them.
- Inputs presented with in_valid=0 or in_ready=0 are ignored. The producer holds them until accepted.
- Wrap-around: sum is modulo 2^WIDTH. cout carries bit WIDTH.
- Simultaneous input accept and output handoff in the same cycle is legal and required for full throughput.

Test Plan (WIDTH=16, STAGES=4 unless noted):
- Reset then idle: rst_n=0 for 3 cycles → out_valid=0, sum=0x0000, in_ready=1. Release: out_valid stays 0 with no input.
- Cross-segment carry: a=0x00FF, b=0x0001, cin=0, sub=0, out_ready=1 → exactly 4 cycles later sum=0x0100, cout=0, ovf=0. Also a=0xFFFF, b=0x0001 → sum=0x0000, cout=1. Also a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1.
- Subtract: a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1. Also a=0x0003, b=0x0005, sub=1 → sum=0xFFFE, cout=0, ovf=0. Also cin=1 with sub=1 has no effect.
- Back-to-back: 8 consecutive operands (k+5)+(k+4), k=0..7, out_valid every cycle from cycle 4 → sums 0x0009,0x000B,…,0x0017 in order, no gaps.
- Backpressure: stream 6 ops, drop out_ready for 3 cycles mid-stream → in_ready=0 during the stall, sum held stable, all 6 results delivered in order with no loss or duplication.
- Reset mid-flight: accept 3 ops, assert rst_n=0 on cycle 2 for 1 cycle → out_valid=0 immediately (asynchronously) and no stale result ever appears. Repeat the carry scenario with WIDTH=8, STAGES=1 (1-cycle latency, 5+4 → 0x09) and WIDTH=8, STAGES=8.
